// File: rtl/csp_demux1.sv
// Clocked four-phase CSP split: joins one data token and one select token,
// then forwards the data on out0 or out1 according to the select value.
module csp_demux1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  input  logic             sel_req,
  input  logic             sel_data,
  output logic             sel_ack,
  output logic             out0_req,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ack,
  output logic             out1_req,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ack,
  output logic             proto_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q;
  logic             route_q;
  logic [WIDTH-1:0] data_q;
  logic             in_ack_q, sel_ack_q;
  logic             out0_req_q, out1_req_q;
  logic [WIDTH-1:0] out0_data_q, out1_data_q;
  logic             proto_err_q;
  logic             in_prev_q, sel_prev_q;

  // Request/ack of whichever output the current token is routed to.
  logic rt_req, rt_ack;
  assign rt_req = route_q ? out1_req_q : out0_req_q;
  assign rt_ack = route_q ? out1_ack   : out0_ack;

  // An output is live from accept until its ack has fallen again, i.e. for
  // the whole BUSY period when it is the routed one.
  logic out0_live, out1_live;
  assign out0_live = (state_q == BUSY) && !route_q;
  assign out1_live = (state_q == BUSY) &&  route_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      route_q     <= 1'b0;
      data_q      <= '0;
      in_ack_q    <= 1'b0;
      sel_ack_q   <= 1'b0;
      out0_req_q  <= 1'b0;
      out1_req_q  <= 1'b0;
      out0_data_q <= '0;
      out1_data_q <= '0;
      proto_err_q <= 1'b0;
      in_prev_q   <= 1'b0;
      sel_prev_q  <= 1'b0;
    end else begin
      in_prev_q  <= in_req;
      sel_prev_q <= sel_req;
      if ((out0_ack && !out0_live) || (out1_ack && !out1_live))
        proto_err_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (in_req && sel_req) begin
            data_q    <= in_data;
            route_q   <= sel_data;
            in_ack_q  <= 1'b1;
            sel_ack_q <= 1'b1;
            if (sel_data) begin
              out1_req_q  <= 1'b1;
              out1_data_q <= in_data;
            end else begin
              out0_req_q  <= 1'b1;
              out0_data_q <= in_data;
            end
            state_q <= BUSY;
          end else if ((in_prev_q && !in_req) || (sel_prev_q && !sel_req)) begin
            // A request withdrawn before it was ever acknowledged.
            proto_err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (!in_req)  in_ack_q  <= 1'b0;
          if (!sel_req) sel_ack_q <= 1'b0;
          if (rt_ack) begin
            if (route_q) out1_req_q <= 1'b0;
            else         out0_req_q <= 1'b0;
          end
          if (!in_ack_q && !sel_ack_q && !rt_req && !rt_ack)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ack    = in_ack_q;
  assign sel_ack   = sel_ack_q;
  assign out0_req  = out0_req_q;
  assign out1_req  = out1_req_q;
  assign out0_data = out0_data_q;
  assign out1_data = out1_data_q;
  assign proto_err = proto_err_q;

endmodule
